// File: rtl/dram_scheduler.sv
// dram_scheduler
// Shares one DRAM command port between the sample-load write stream and
// per-voice playback read requests. Reads win for latency, except that after
// WRITE_STARVE_LIMIT consecutive read grants with a write waiting, the write
// is forced through. Read responses return in command order and are routed
// back to their requester through an in-order tag FIFO.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   wr_axis_*           write word stream (tvalid/tready/tdata/tlast)
//   load_start          pulse: restart write address at 0, clear write_done
//   write_done          set when the tlast word is accepted by DRAM
//   rd_req_valid/ready  per-requester read request / one-hot grant
//   rd_req_addr         per-requester word address
//   rsp_valid/id/data   registered read response with requester index
//   rsp_orphan          sticky: read data arrived with no outstanding tag
//   cmd_*               DRAM command port (held until cmd_ready)
//   dram_rd_valid/data  DRAM read data return, in command order
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cmd_valid and its payload never change while cmd_valid is high
// and cmd_ready is low. rd_req_ready and wr_axis_tready are combinational
// grants; at most one is high, and both are low while the command slot is
// occupied and not being accepted, or while reset is asserted.
module dram_scheduler #(
    parameter int REQUESTERS         = 8,
    parameter int ADDR_WIDTH         = 24,
    parameter int MAX_OUTSTANDING    = 8,
    parameter int WRITE_STARVE_LIMIT = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_axis_tvalid,
    output logic                                  wr_axis_tready,
    input  logic [127:0]                          wr_axis_tdata,
    input  logic                                  wr_axis_tlast,
    input  logic                                  load_start,
    output logic                                  write_done,
    input  logic [REQUESTERS-1:0]                 rd_req_valid,
    output logic [REQUESTERS-1:0]                 rd_req_ready,
    input  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] rd_req_addr,
    output logic                                  rsp_valid,
    output logic [$clog2(REQUESTERS)-1:0]         rsp_id,
    output logic [127:0]                          rsp_data,
    output logic                                  rsp_orphan,
    output logic                                  cmd_valid,
    input  logic                                  cmd_ready,
    output logic                                  cmd_write,
    output logic [ADDR_WIDTH-1:0]                 cmd_addr,
    output logic [127:0]                          cmd_wdata,
    input  logic                                  dram_rd_valid,
    input  logic [127:0]                          dram_rd_data
);

    localparam int ID_W  = $clog2(REQUESTERS);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(WRITE_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] TAG_FULL   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(WRITE_STARVE_LIMIT);

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [SC_W-1:0]       starve_cnt;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       rr_idx;
    logic                  rr_found;
    logic                  cmd_last;

    logic [ID_W-1:0]       tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      tag_wr_ptr;
    logic [PTR_W-1:0]      tag_rd_ptr;
    logic [CNT_W-1:0]      tag_count;
    logic                  tag_pop;

    logic slot_free;
    logic rd_elig;
    logic wr_elig;
    logic grant_wr;
    logic grant_rd;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            if (!rr_found && rd_req_valid[(int'(rr_ptr) + k) % REQUESTERS]) begin
                rr_found = 1'b1;
                rr_idx   = ID_W'((int'(rr_ptr) + k) % REQUESTERS);
            end
        end
    end

    // Grants are gated by rst so all outputs read 0 while reset is held.
    assign slot_free = rst && (!cmd_valid || cmd_ready);
    assign rd_elig   = rr_found && (tag_count < TAG_FULL);
    assign wr_elig   = wr_axis_tvalid && !load_start;
    assign grant_wr  = slot_free && wr_elig && ((starve_cnt == STARVE_MAX) || !rd_elig);
    assign grant_rd  = slot_free && rd_elig && !grant_wr;
    assign tag_pop   = dram_rd_valid && (tag_count != '0);

    assign wr_axis_tready = grant_wr;

    always_comb begin
        rd_req_ready = '0;
        if (grant_rd) rd_req_ready[rr_idx] = 1'b1;
    end

    // Command register: reloads on the same edge as a handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_last  <= 1'b0;
        end else if (slot_free) begin
            if (grant_wr) begin
                cmd_valid <= 1'b1;
                cmd_write <= 1'b1;
                cmd_addr  <= wr_addr;
                cmd_wdata <= wr_axis_tdata;
                cmd_last  <= wr_axis_tlast;
            end else if (grant_rd) begin
                cmd_valid <= 1'b1;
                cmd_write <= 1'b0;
                cmd_addr  <= rd_req_addr[rr_idx];
                cmd_wdata <= '0;
                cmd_last  <= 1'b0;
            end else begin
                cmd_valid <= 1'b0;
            end
        end
    end

    // Write address, starvation counter, round-robin pointer, load status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr    <= '0;
            starve_cnt <= '0;
            rr_ptr     <= ID_W'(REQUESTERS - 1);
            write_done <= 1'b0;
        end else begin
            if (load_start)    wr_addr <= '0;
            else if (grant_wr) wr_addr <= wr_addr + 1'b1;

            if (grant_wr)
                starve_cnt <= '0;
            else if (grant_rd && wr_elig && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;

            if (grant_rd) rr_ptr <= rr_idx;

            if (load_start)
                write_done <= 1'b0;
            else if (cmd_valid && cmd_ready && cmd_write && cmd_last)
                write_done <= 1'b1;
        end
    end

    // Tag storage needs no reset: only entries below tag_count are read.
    always_ff @(posedge clk) begin
        if (grant_rd) tag_mem[tag_wr_ptr] <= rr_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_count  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_orphan <= 1'b0;
        end else begin
            if (grant_rd) tag_wr_ptr <= tag_wr_ptr + 1'b1;
            if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + 1'b1;
            case ({grant_rd, tag_pop})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: tag_count <= tag_count;
            endcase

            rsp_valid <= tag_pop;
            if (tag_pop) begin
                rsp_id   <= tag_mem[tag_rd_ptr];
                rsp_data <= dram_rd_data;
            end
            if (dram_rd_valid && (tag_count == '0)) rsp_orphan <= 1'b1;
        end
    end

endmodule
